// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: buffers received characters with a per-entry BREAK
// flag, first-word fall-through read port, sticky overrun, level
// interrupt and idle-timeout interrupt.
module uart_rx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH        = 16,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wr_valid,
  input  logic [PAYLOAD_BITS-1:0] wr_data,
  input  logic                    wr_break,
  input  logic                    rd_en,
  input  logic                    flush,
  input  logic                    clr_overrun,
  input  logic [AW:0]             threshold,
  input  logic [15:0]             timeout_cycles,
  output logic [PAYLOAD_BITS-1:0] rd_data,
  output logic                    rd_break,
  output logic                    empty,
  output logic                    full,
  output logic [AW:0]             level,
  output logic                    overrun,
  output logic                    irq_level,
  output logic                    irq_timeout
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

  logic [PAYLOAD_BITS:0] mem [DEPTH];
  logic [PAYLOAD_BITS:0] head;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [15:0]           tmo_cnt;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  drop;

  // Accept/drop decisions; a read frees a slot so a write into a full FIFO
  // is still accepted when paired with a read.
  always_comb begin
    rd_acc = rd_en & ~empty;
    wr_acc = wr_valid & (~full | rd_acc);
    drop   = wr_valid & full & ~rd_en;
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) begin
      mem[wr_ptr] <= {wr_break, wr_data};
    end
  end

  // Pointers and fill level; flush overrides any same-cycle traffic.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_acc && !rd_acc) begin
        level <= level + LVL_ONE;
      end else if (rd_acc && !wr_acc) begin
        level <= level - LVL_ONE;
      end
    end
  end

  // Sticky overrun: a drop beats a same-cycle clear; flush suppresses the drop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun <= 1'b0;
    end else if (drop && !flush) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  // Idle-timeout counter and interrupt; fires timeout_cycles edges after
  // the last accepted access while data is pending.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt     <= '0;
      irq_timeout <= 1'b0;
    end else if (flush) begin
      tmo_cnt     <= '0;
      irq_timeout <= 1'b0;
    end else begin
      if (wr_acc || rd_acc || empty) begin
        tmo_cnt <= '0;
      end else if (timeout_cycles != '0 && !irq_timeout) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end

      if (wr_acc || rd_acc || timeout_cycles == '0) begin
        irq_timeout <= 1'b0;
      end else if (!empty && !irq_timeout && tmo_cnt == timeout_cycles - 16'd1) begin
        irq_timeout <= 1'b1;
      end
    end
  end

  // Status flags, level interrupt and zero-gated fall-through head.
  always_comb begin
    empty     = (level == '0);
    full      = (level == LVL_FULL);
    irq_level = (threshold != '0) && (level >= threshold);
    head      = mem[rd_ptr];
    if (empty) begin
      rd_data  = '0;
      rd_break = 1'b0;
    end else begin
      rd_data  = head[PAYLOAD_BITS-1:0];
      rd_break = head[PAYLOAD_BITS];
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized
// traffic, every cycle compared against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int PB = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wr_valid;
  logic [PB-1:0] wr_data;
  logic          wr_break;
  logic          rd_en;
  logic          flush;
  logic          clr_overrun;
  logic [AW:0]   threshold;
  logic [15:0]   timeout_cycles;
  logic [PB-1:0] rd_data;
  logic          rd_break;
  logic          empty;
  logic          full;
  logic [AW:0]   level;
  logic          overrun;
  logic          irq_level;
  logic          irq_timeout;

  always #5 clk = ~clk;

  uart_rx_fifo #(.PAYLOAD_BITS(PB), .DEPTH(D)) dut (
    .clk(clk), .resetn(resetn), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_break(wr_break), .rd_en(rd_en), .flush(flush),
    .clr_overrun(clr_overrun), .threshold(threshold),
    .timeout_cycles(timeout_cycles), .rd_data(rd_data), .rd_break(rd_break),
    .empty(empty), .full(full), .level(level), .overrun(overrun),
    .irq_level(irq_level), .irq_timeout(irq_timeout)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents, sticky flag, edges since last access.
  logic [PB:0] q[$];
  logic        m_ovr;
  int          m_idle;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, "/level"}, 32'(level), 32'(n));
    check({tag, "/empty"}, 32'(empty), 32'(n == 0));
    check({tag, "/full"}, 32'(full), 32'(n == D));
    check({tag, "/rd_data"}, 32'(rd_data), (n == 0) ? 32'd0 : 32'(q[0][PB-1:0]));
    check({tag, "/rd_break"}, 32'(rd_break), (n == 0) ? 32'd0 : 32'(q[0][PB]));
    check({tag, "/overrun"}, 32'(overrun), 32'(m_ovr));
    check({tag, "/irq_level"}, 32'(irq_level), 32'(threshold != 0 && n >= int'(threshold)));
    check({tag, "/irq_timeout"}, 32'(irq_timeout),
          32'(n != 0 && timeout_cycles != 0 && m_idle >= int'(timeout_cycles)));
  endtask

  // One clock edge: advance the model from the current inputs, then compare.
  task automatic cycle(input string tag);
    int n;
    bit do_rd, do_wr;
    n = q.size();
    if (flush) begin
      q.delete();
      m_idle = 0;
      if (clr_overrun) m_ovr = 1'b0;
    end else begin
      do_rd = rd_en && n > 0;
      do_wr = wr_valid && (n < D || do_rd);
      if (wr_valid && n == D && !rd_en) m_ovr = 1'b1;
      else if (clr_overrun) m_ovr = 1'b0;
      if (do_rd) void'(q.pop_front());
      if (do_wr) q.push_back({wr_break, wr_data});
      if (do_rd || do_wr) m_idle = 0;
      else if (m_idle < 1000000) m_idle++;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic push(input logic [PB-1:0] d, input logic b, input string tag);
    wr_valid = 1'b1; wr_data = d; wr_break = b;
    cycle(tag);
    wr_valid = 1'b0; wr_data = '0; wr_break = 1'b0;
  endtask

  task automatic pop(input string tag);
    rd_en = 1'b1;
    cycle(tag);
    rd_en = 1'b0;
  endtask

  task automatic do_flush(input string tag);
    flush = 1'b1;
    cycle(tag);
    flush = 1'b0;
  endtask

  // Asynchronous reset asserted between edges; outputs checked before the next edge.
  task automatic async_reset(input string tag);
    resetn = 1'b0;
    #2;
    q.delete();
    m_ovr  = 1'b0;
    m_idle = 0;
    check_all(tag);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int pw, pr;
    resetn = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_break = 1'b0;
    rd_en = 1'b0; flush = 1'b0; clr_overrun = 1'b0;
    threshold = '0; timeout_cycles = '0;
    m_ovr = 1'b0; m_idle = 0;
    #12;
    check_all("reset");
    check("reset/empty_const", 32'(empty), 32'd1);
    @(negedge clk);
    resetn = 1'b1;

    // Three characters in, three out in order.
    push(8'h41, 1'b0, "w41");
    push(8'h42, 1'b0, "w42");
    push(8'h43, 1'b0, "w43");
    check("basic/level3", 32'(level), 32'd3);
    check("basic/head41", 32'(rd_data), 32'h41);
    pop("p1");
    check("basic/head42", 32'(rd_data), 32'h42);
    pop("p2");
    check("basic/head43", 32'(rd_data), 32'h43);
    pop("p3");
    check("basic/empty", 32'(empty), 32'd1);
    check("basic/zero", 32'(rd_data), 32'd0);
    pop("p_empty");

    // Overfill by one: 17th dropped, overrun set, first 16 come out in order.
    for (int i = 0; i < 17; i++) push(8'(8'h10 + i), 1'b0, "fill17");
    check("ovr/full", 32'(full), 32'd1);
    check("ovr/level", 32'(level), 32'd16);
    check("ovr/flag", 32'(overrun), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("ovr/order", 32'(rd_data), 32'(8'h10 + i));
      pop("drain16");
    end
    check("ovr/empty", 32'(empty), 32'd1);
    clr_overrun = 1'b1;
    cycle("clr");
    clr_overrun = 1'b0;
    check("ovr/cleared", 32'(overrun), 32'd0);

    // Full with simultaneous write and read.
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1'b0, "fill16");
    wr_valid = 1'b1; wr_data = 8'h99; rd_en = 1'b1;
    cycle("wr_rd_full");
    wr_valid = 1'b0; rd_en = 1'b0;
    check("wrrd/level", 32'(level), 32'd16);
    check("wrrd/no_ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < 15; i++) pop("drain_wrrd");
    check("wrrd/last", 32'(rd_data), 32'h99);
    pop("drain_last");

    // Empty with simultaneous write and read.
    wr_valid = 1'b1; wr_data = 8'h5a; rd_en = 1'b1;
    cycle("wr_rd_empty");
    wr_valid = 1'b0; rd_en = 1'b0;
    check("wrrd_e/level", 32'(level), 32'd1);
    pop("pe");

    // BREAK entry and level interrupt.
    push(8'h00, 1'b1, "brk");
    check("brk/flag", 32'(rd_break), 32'd1);
    check("brk/data", 32'(rd_data), 32'd0);
    pop("brk_pop");
    threshold = 5'd4;
    for (int i = 0; i < 3; i++) push(8'(8'h60 + i), 1'b0, "thr");
    check("thr/below", 32'(irq_level), 32'd0);
    push(8'h63, 1'b0, "thr4");
    check("thr/at", 32'(irq_level), 32'd1);
    pop("thr_pop");
    check("thr/drop", 32'(irq_level), 32'd0);
    do_flush("thr_flush");
    threshold = '0;

    // Idle timeout after ten cycles.
    timeout_cycles = 16'd10;
    push(8'h77, 1'b0, "tmo_w");
    for (int k = 1; k <= 10; k++) begin
      cycle("tmo_idle");
      check("tmo/edge", 32'(irq_timeout), 32'(k == 10));
    end
    cycle("tmo_hold");
    pop("tmo_pop");
    check("tmo/clear", 32'(irq_timeout), 32'd0);
    check("tmo/empty", 32'(empty), 32'd1);
    timeout_cycles = '0;

    // Flush with a same-cycle write keeps overrun; then reset mid-stream.
    for (int i = 0; i < 17; i++) push(8'(i), 1'b0, "fill_f");
    wr_valid = 1'b1; wr_data = 8'hee; rd_en = 1'b1; flush = 1'b1;
    cycle("flush_wr");
    wr_valid = 1'b0; rd_en = 1'b0; flush = 1'b0;
    check("flush/empty", 32'(empty), 32'd1);
    check("flush/level", 32'(level), 32'd0);
    check("flush/ovr_kept", 32'(overrun), 32'd1);
    for (int i = 0; i < 3; i++) push(8'(8'h30 + i), 1'b0, "pre_rst");
    async_reset("rst_mid");
    check("rst/level", 32'(level), 32'd0);
    check("rst/ovr", 32'(overrun), 32'd0);
    push(8'h88, 1'b1, "post_rst");
    check("rst/head", 32'(rd_data), 32'h88);
    check("rst/lvl1", 32'(level), 32'd1);
    do_flush("post_rst_flush");

    // Randomized traffic; timeout length only changes while empty.
    for (int ph = 0; ph < 8; ph++) begin
      pw = (ph % 2 == 0) ? 70 : 35;
      pr = (ph % 2 == 0) ? 30 : 65;
      timeout_cycles = (ph % 3 == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      for (int c = 0; c < 250; c++) begin
        wr_valid    = ($urandom_range(99) < pw);
        wr_data     = 8'($urandom);
        wr_break    = ($urandom_range(9) == 0);
        rd_en       = ($urandom_range(99) < pr);
        flush       = ($urandom_range(99) < 2);
        clr_overrun = ($urandom_range(99) < 5);
        if ($urandom_range(9) == 0) threshold = 5'($urandom_range(16));
        if ($urandom_range(99) < 15) begin
          wr_valid = 1'b0; rd_en = 1'b0;
        end
        cycle("rand");
      end
      wr_valid = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0;
      do_flush("rand_end");
      if (ph == 4) async_reset("rand_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
